// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: req/ack data-memory port between the MEM stage and data memory
interface mem_access_unit_if;
  logic req;
  logic we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic ack;
  logic [31:0] rdata;
  modport master(output req, we, addr, wdata, input ack, rdata);
  modport slave(input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine with req/ack memory port, stall and MEM/WB register
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic clrn,
  input  logic MEMwreg,
  input  logic MEMm2reg,
  input  logic MEMwmem,
  input  logic MEMisStoreHazards,
  input  logic [4:0] MEMwn,
  input  logic [31:0] MEMaluResult,
  input  logic [31:0] MEMdi,
  input  logic [31:0] WBfwd,
  mem_access_unit_if.master dmem,
  output logic stall,
  output logic bus_err,
  output logic WBwreg,
  output logic WBm2reg,
  output logic [4:0] WBwn,
  output logic [31:0] WBaluResult,
  output logic [31:0] WBmo
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, nxt;
  logic [7:0] cnt;
  logic [31:0] rdata_hold;
  logic access, expire;
  assign access = MEMm2reg | MEMwmem;
  assign expire = cnt == 8'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state == IDLE ? (access ? BUSY : IDLE) :
          state == BUSY ? ((dmem.ack | expire) ? DONE : BUSY) : IDLE;
  end
  always_comb begin
    stall = state == BUSY | (state == IDLE & access);
  end
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      dmem.req <= 1'b0;
      dmem.we <= 1'b0;
      dmem.addr <= '0;
      dmem.wdata <= '0;
      cnt <= '0;
      rdata_hold <= '0;
      bus_err <= 1'b0;
    end else if (state == IDLE && access) begin
      dmem.req <= 1'b1;
      dmem.we <= MEMwmem;
      dmem.addr <= MEMaluResult;
      dmem.wdata <= MEMisStoreHazards ? WBfwd : MEMdi;
      cnt <= '0;
    end else if (state == BUSY) begin
      if (dmem.ack) begin
        dmem.req <= 1'b0;
        rdata_hold <= dmem.we ? '0 : dmem.rdata;
      end else if (expire) begin
        dmem.req <= 1'b0;
        bus_err <= 1'b1;
        rdata_hold <= '0;
      end else cnt <= cnt + 8'd1;
    end
  // a stalled cycle writes a bubble so the held instruction is written back only once
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      WBwreg <= 1'b0;
      WBm2reg <= 1'b0;
      WBwn <= '0;
      WBaluResult <= '0;
      WBmo <= '0;
    end else begin
      WBwreg <= !stall & MEMwreg;
      WBm2reg <= !stall & MEMm2reg;
      WBwn <= stall ? '0 : MEMwn;
      WBaluResult <= stall ? '0 : MEMaluResult;
      WBmo <= (!stall && state == DONE) ? rdata_hold : '0;
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vectors with a scoreboard for MEM/WB writes and memory requests
module tb_mem_access_unit;
  localparam int TO = 4;
  logic clk = 0, clrn = 1;
  logic MEMwreg = 0, MEMm2reg = 0, MEMwmem = 0, MEMisStoreHazards = 0;
  logic [4:0] MEMwn = 0;
  logic [31:0] MEMaluResult = 0, MEMdi = 0, WBfwd = 0;
  logic stall, bus_err, WBwreg, WBm2reg;
  logic [4:0] WBwn;
  logic [31:0] WBaluResult, WBmo;
  int vectors = 0, miscompares = 0;
  typedef struct packed {logic wreg; logic m2reg; logic [4:0] wn; logic [31:0] alu; logic [31:0] mo;} wb_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; int len;} tx_t;
  wb_t wb_q[$];
  tx_t tx_q[$];
  mem_access_unit_if dmem();
  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .clrn(clrn),
    .MEMwreg(MEMwreg), .MEMm2reg(MEMm2reg), .MEMwmem(MEMwmem),
    .MEMisStoreHazards(MEMisStoreHazards), .MEMwn(MEMwn),
    .MEMaluResult(MEMaluResult), .MEMdi(MEMdi), .WBfwd(WBfwd),
    .dmem(dmem), .stall(stall), .bus_err(bus_err),
    .WBwreg(WBwreg), .WBm2reg(WBm2reg), .WBwn(WBwn),
    .WBaluResult(WBaluResult), .WBmo(WBmo)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic req_d = 0;
  int req_len = 0;
  tx_t cur = '{1'b0, 32'h0, 32'h0, -1};
  always @(negedge clk) begin
    wb_t got;
    got = {WBwreg, WBm2reg, WBwn, WBaluResult, WBmo};
    if (|got) begin
      if (wb_q.size() == 0) chk("wb_unexpected", 128'(got), 128'h0);
      else chk("wb", 128'(got), 128'(wb_q.pop_front()));
    end
    if (dmem.req === 1'b1) begin
      if (!req_d) begin
        req_len = 0;
        if (tx_q.size() == 0) begin
          chki("req_unexpected", 1, 0);
          cur.len = -1;
        end else begin
          cur = tx_q.pop_front();
          chk("req_fields", 128'({dmem.we, dmem.addr, dmem.wdata}), 128'({cur.we, cur.addr, cur.wdata}));
        end
      end else chk("req_stable", 128'({dmem.we, dmem.addr, dmem.wdata}), 128'({cur.we, cur.addr, cur.wdata}));
      req_len++;
    end else if (req_d && cur.len >= 0) chki("req_len", req_len, cur.len);
    req_d = dmem.req === 1'b1;
  end

  task automatic clear_mem;
    {MEMwreg, MEMm2reg, MEMwmem, MEMisStoreHazards} = 4'b0;
    MEMwn = 0;
    MEMaluResult = 0;
    MEMdi = 0;
    WBfwd = 0;
  endtask

  // k = BUSY cycle in which ack is given (1 = first); k = 0 never acks
  task automatic issue(input string name, input logic wreg, m2reg, wmem, haz,
                       input logic [4:0] wn, input logic [31:0] alu, di, fwd,
                       input int k, input logic [31:0] rdata);
    int sc = 0;
    bit done = 0;
    bit acc = m2reg | wmem;
    {MEMwreg, MEMm2reg, MEMwmem, MEMisStoreHazards} = {wreg, m2reg, wmem, haz};
    MEMwn = wn;
    MEMaluResult = alu;
    MEMdi = di;
    WBfwd = fwd;
    dmem.rdata = rdata;
    if (acc) tx_q.push_back('{wmem, alu, haz ? fwd : di, k == 0 ? TO : k});
    wb_q.push_back({wreg, m2reg, wn, alu, (m2reg && !wmem && k != 0) ? rdata : 32'h0});
    for (int c = 0; c < 300 && !done; c++) begin
      dmem.ack = acc && k != 0 && c == k;
      if (c == 1) WBfwd = ~fwd;
      @(negedge clk);
      if (stall) sc++;
      else done = 1;
      @(posedge clk);
      #1;
    end
    dmem.ack = 0;
    if (!done) chki({name, "_hang"}, 0, 1);
    chki({name, "_stall"}, sc, acc ? (k == 0 ? TO + 1 : k + 1) : 0);
  endtask

  initial begin
    dmem.ack = 0;
    dmem.rdata = 0;
    #1 clrn = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", 128'({dmem.req, dmem.we, dmem.addr, dmem.wdata, bus_err, stall}), 128'h0);
    chk("rst_wb", 128'({WBwreg, WBm2reg, WBwn, WBaluResult, WBmo}), 128'h0);
    clrn = 1;
    @(posedge clk);
    #1;
    issue("alu", 1, 0, 0, 0, 5'd5, 32'h1234, 32'h0, 32'h0, 0, 32'h0);
    clear_mem();
    issue("load", 1, 1, 0, 0, 5'd7, 32'h40, 32'h0, 32'h0, 1, 32'hDEADBEEF);
    clear_mem();
    issue("store_haz", 0, 0, 1, 1, 5'd3, 32'h80, 32'h11, 32'h22, 3, 32'h55AA55AA);
    clear_mem();
    chki("bus_err_before", int'(bus_err), 0);
    issue("timeout", 1, 1, 0, 0, 5'd9, 32'h100, 32'h0, 32'h0, 0, 32'h0);
    clear_mem();
    chki("bus_err_set", int'(bus_err), 1);
    issue("b2b_0", 1, 1, 0, 0, 5'd10, 32'h0, 32'h0, 32'h0, 1, 32'hA0A0A0A0);
    issue("b2b_1", 1, 1, 0, 0, 5'd11, 32'h4, 32'h0, 32'h0, 1, 32'hB1B1B1B1);
    clear_mem();
    repeat (2) @(negedge clk);
    chki("bus_err_sticky", int'(bus_err), 1);
    @(posedge clk);
    #1;
    MEMwreg = 1;
    MEMm2reg = 1;
    MEMwn = 5'd12;
    MEMaluResult = 32'h200;
    tx_q.push_back('{1'b0, 32'h200, 32'h0, -1});
    repeat (2) @(posedge clk);
    #1 clrn = 0;
    clear_mem();
    #1;
    chk("midrst_req_stall", 128'({dmem.req, stall, bus_err}), 128'h0);
    chk("midrst_wb", 128'({WBwreg, WBm2reg, WBwn, WBaluResult, WBmo}), 128'h0);
    @(negedge clk);
    clrn = 1;
    dmem.ack = 1;
    dmem.rdata = 32'hFFFF0000;
    repeat (3) @(negedge clk);
    chk("spurious_ack", 128'({dmem.req, stall, WBmo}), 128'h0);
    dmem.ack = 0;
    repeat (3) @(negedge clk);
    chki("wb_q_left", wb_q.size(), 0);
    chki("tx_q_left", tx_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
